// File: rtl/leve_pkg.sv
// rtl/leve_pkg.sv - shared defaults and types for the register file / scoreboard slice
package leve_pkg;

    localparam int unsigned XLEN_DEF    = 64;
    localparam int unsigned NUM_REG_DEF = 32;
    localparam int unsigned RA_W_DEF    = $clog2(NUM_REG_DEF);

    // Encoding 3 is reserved and decodes like RS2_REG.
    typedef enum logic [1:0] {
        RS2_REG  = 2'd0,
        RS2_IMM  = 2'd1,
        RS2_ZERO = 2'd2
    } rs2sel_t;

    typedef logic [RA_W_DEF-1:0] reg_idx_t;

endpackage

// File: rtl/leve_scoreboard.sv
// rtl/leve_scoreboard.sv - per-register busy bits with set/clear/flush and hazard queries
module leve_scoreboard
    import leve_pkg::*;
#(
    parameter  int unsigned NUM_REG = NUM_REG_DEF,
    localparam int unsigned RA_W    = $clog2(NUM_REG)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               set_i,
    input  logic [RA_W-1:0]    set_idx_i,
    input  logic               clr_i,
    input  logic [RA_W-1:0]    clr_idx_i,
    input  logic               flush_i,
    input  logic               q_rs1_en_i,
    input  logic [RA_W-1:0]    q_rs1_i,
    input  logic               q_rs2_en_i,
    input  logic [RA_W-1:0]    q_rs2_i,
    input  logic               q_rd_en_i,
    input  logic [RA_W-1:0]    q_rd_i,
    output logic [NUM_REG-1:0] busy_o,
    output logic               rs1_haz_o,
    output logic               rs2_haz_o,
    output logic               waw_o
);

    logic [NUM_REG-1:0] busy_q, busy_d;

    // A busy register being written back this cycle is no longer a hazard.
    function automatic logic hazard(input logic [NUM_REG-1:0] busy,
                                    input logic               en,
                                    input logic [RA_W-1:0]    idx,
                                    input logic               clr,
                                    input logic [RA_W-1:0]    clr_idx);
        logic hit;
        hit = 1'b0;
        for (int i = 1; i < NUM_REG; i++) begin
            if (idx == i[RA_W-1:0]) begin
                hit = busy[i];
            end
        end
        return en && hit && !(clr && (clr_idx == idx));
    endfunction

    always_comb begin
        rs1_haz_o = hazard(busy_q, q_rs1_en_i, q_rs1_i, clr_i, clr_idx_i);
        rs2_haz_o = hazard(busy_q, q_rs2_en_i, q_rs2_i, clr_i, clr_idx_i);
        waw_o     = hazard(busy_q, q_rd_en_i,  q_rd_i,  clr_i, clr_idx_i);
    end

    always_comb begin
        busy_d = busy_q;
        if (flush_i) begin
            busy_d = '0;
        end else begin
            for (int i = 0; i < NUM_REG; i++) begin
                if (clr_i && (clr_idx_i == i[RA_W-1:0])) begin
                    busy_d[i] = 1'b0;
                end
                if (set_i && (set_idx_i == i[RA_W-1:0])) begin
                    busy_d[i] = 1'b1;
                end
            end
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_o = busy_q;

endmodule

// File: rtl/leve_irf_sb.sv
// rtl/leve_irf_sb.sv - integer register file with operand read stage, WB bypass and busy scoreboard
module leve_irf_sb
    import leve_pkg::*;
#(
    parameter  int unsigned XLEN    = XLEN_DEF,
    parameter  int unsigned NUM_REG = NUM_REG_DEF,
    localparam int unsigned RA_W    = $clog2(NUM_REG)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               iss_valid_i,
    output logic               iss_ready_o,
    input  logic               iss_rs1_en_i,
    input  logic [RA_W-1:0]    iss_rs1_i,
    input  logic               iss_rs2_en_i,
    input  logic [RA_W-1:0]    iss_rs2_i,
    input  logic [1:0]         iss_rs2sel_i,
    input  logic [XLEN-1:0]    iss_imm_i,
    input  logic               iss_rd_en_i,
    input  logic [RA_W-1:0]    iss_rd_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [XLEN-1:0]    out_rs1_d_o,
    output logic [XLEN-1:0]    out_rs2_d_o,
    output logic [RA_W-1:0]    out_rd_o,
    input  logic               wb_we_i,
    input  logic [RA_W-1:0]    wb_rd_i,
    input  logic [XLEN-1:0]    wb_data_i,
    input  logic               flush_i,
    output logic [NUM_REG-1:0] busy_vec_o
);

    logic [XLEN-1:0] regs_q [NUM_REG];

    logic            rs2_is_reg;
    logic            rs1_haz, rs2_haz, waw;
    logic            accept;
    logic [XLEN-1:0] rs1_rd, rs2_rd;

    logic            out_valid_q, out_valid_d;
    logic [XLEN-1:0] out_rs1_q, out_rs1_d;
    logic [XLEN-1:0] out_rs2_q, out_rs2_d;
    logic [RA_W-1:0] out_rd_q, out_rd_d;

    assign rs2_is_reg = iss_rs2_en_i &&
                        ((iss_rs2sel_i == RS2_REG) || (iss_rs2sel_i == 2'd3));

    leve_scoreboard #(
        .NUM_REG (NUM_REG)
    ) u_sb (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .set_i      (accept && iss_rd_en_i && (iss_rd_i != '0)),
        .set_idx_i  (iss_rd_i),
        .clr_i      (wb_we_i),
        .clr_idx_i  (wb_rd_i),
        .flush_i    (flush_i),
        .q_rs1_en_i (iss_rs1_en_i),
        .q_rs1_i    (iss_rs1_i),
        .q_rs2_en_i (rs2_is_reg),
        .q_rs2_i    (iss_rs2_i),
        .q_rd_en_i  (iss_rd_en_i),
        .q_rd_i     (iss_rd_i),
        .busy_o     (busy_vec_o),
        .rs1_haz_o  (rs1_haz),
        .rs2_haz_o  (rs2_haz),
        .waw_o      (waw)
    );

    assign iss_ready_o = !flush_i && !rs1_haz && !rs2_haz && !waw &&
                         (!out_valid_q || out_ready_i);
    assign accept      = iss_valid_i && iss_ready_o;

    function automatic logic [XLEN-1:0] read_port(input logic [RA_W-1:0] idx,
                                                  input logic [XLEN-1:0] arr_val,
                                                  input logic            we,
                                                  input logic [RA_W-1:0] wrd,
                                                  input logic [XLEN-1:0] wdata);
        if (idx == '0) begin
            return '0;
        end else if (we && (wrd == idx)) begin
            return wdata;
        end
        return arr_val;
    endfunction

    always_comb begin
        rs1_rd = read_port(iss_rs1_i, regs_q[iss_rs1_i], wb_we_i, wb_rd_i, wb_data_i);
        rs2_rd = read_port(iss_rs2_i, regs_q[iss_rs2_i], wb_we_i, wb_rd_i, wb_data_i);
    end

    // Register array is deliberately not reset; x0 is never written and reads as zero.
    always_ff @(posedge clk_i) begin
        if (rst_ni && wb_we_i && (wb_rd_i != '0)) begin
            regs_q[wb_rd_i] <= wb_data_i;
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_rs1_d   = out_rs1_q;
        out_rs2_d   = out_rs2_q;
        out_rd_d    = out_rd_q;
        if (flush_i) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d = 1'b1;
            out_rs1_d   = iss_rs1_en_i ? rs1_rd : '0;
            out_rd_d    = iss_rd_en_i ? iss_rd_i : '0;
            case (iss_rs2sel_i)
                RS2_IMM:  out_rs2_d = iss_imm_i;
                RS2_ZERO: out_rs2_d = '0;
                default:  out_rs2_d = iss_rs2_en_i ? rs2_rd : '0;
            endcase
        end else if (out_ready_i) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_valid_q <= 1'b0;
            out_rs1_q   <= '0;
            out_rs2_q   <= '0;
            out_rd_q    <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_rs1_q   <= out_rs1_d;
            out_rs2_q   <= out_rs2_d;
            out_rd_q    <= out_rd_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_rs1_d_o = out_rs1_q;
    assign out_rs2_d_o = out_rs2_q;
    assign out_rd_o    = out_rd_q;

endmodule

// File: tb/tb_leve_irf_sb.sv
// tb/tb_leve_irf_sb.sv - scoreboard bench for leve_irf_sb with a reference model
module tb_leve_irf_sb;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        iss_valid = 1'b0, iss_ready;
    logic        rs1_en = 1'b0, rs2_en = 1'b0, rd_en = 1'b0;
    logic [4:0]  rs1 = '0, rs2 = '0, rd = '0;
    logic [1:0]  rs2sel = '0;
    logic [63:0] imm = '0;
    logic        out_valid, out_ready = 1'b0;
    logic [63:0] out_rs1, out_rs2;
    logic [4:0]  out_rd;
    logic        wb_we = 1'b0;
    logic [4:0]  wb_rd = '0;
    logic [63:0] wb_data = '0;
    logic        flush = 1'b0;
    logic [31:0] busy_vec;

    leve_irf_sb dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .iss_valid_i  (iss_valid),
        .iss_ready_o  (iss_ready),
        .iss_rs1_en_i (rs1_en),
        .iss_rs1_i    (rs1),
        .iss_rs2_en_i (rs2_en),
        .iss_rs2_i    (rs2),
        .iss_rs2sel_i (rs2sel),
        .iss_imm_i    (imm),
        .iss_rd_en_i  (rd_en),
        .iss_rd_i     (rd),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
        .out_rs1_d_o  (out_rs1),
        .out_rs2_d_o  (out_rs2),
        .out_rd_o     (out_rd),
        .wb_we_i      (wb_we),
        .wb_rd_i      (wb_rd),
        .wb_data_i    (wb_data),
        .flush_i      (flush),
        .busy_vec_o   (busy_vec)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic        rs1_en;
        logic [4:0]  rs1;
        logic        rs2_en;
        logic [4:0]  rs2;
        logic [1:0]  sel;
        logic [63:0] imm;
        logic        rd_en;
        logic [4:0]  rd;
        logic        ordy;
        logic        we;
        logic [4:0]  wrd;
        logic [63:0] wd;
        logic        fl;
    } stim_t;

    typedef struct {
        logic [63:0] rs1;
        logic [63:0] rs2;
        logic [4:0]  rd;
    } exp_t;

    exp_t        exp_q[$];
    logic [63:0] m_regs [32];
    logic        m_busy [32];
    logic        m_valid = 1'b0;
    int          n_checks = 0;
    int          n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic stim_t idle();
        stim_t s;
        s = '{v: 1'b0, rs1_en: 1'b0, rs1: 5'd0, rs2_en: 1'b0, rs2: 5'd0, sel: 2'd0,
              imm: 64'd0, rd_en: 1'b0, rd: 5'd0, ordy: 1'b1, we: 1'b0, wrd: 5'd0,
              wd: 64'd0, fl: 1'b0};
        return s;
    endfunction

    function automatic logic [31:0] busy_bits();
        logic [31:0] b;
        for (int i = 0; i < 32; i++) b[i] = m_busy[i];
        return b;
    endfunction

    function automatic logic blocked(input stim_t s, input logic en, input logic [4:0] idx);
        return en && idx != 0 && m_busy[idx] && !(s.we && s.wrd == idx);
    endfunction

    function automatic logic [63:0] src(input stim_t s, input logic [4:0] idx);
        if (idx == 0) return 64'd0;
        if (s.we && s.wrd == idx) return s.wd;
        return m_regs[idx];
    endfunction

    // One clock of stimulus: drive, check registered state and ready, then advance the model.
    task automatic step(input stim_t s);
        logic rs2_reg, exp_ready, acc;
        exp_t e;
        @(posedge clk);
        #2;
        iss_valid = s.v;  rs1_en = s.rs1_en; rs1 = s.rs1; rs2_en = s.rs2_en; rs2 = s.rs2;
        rs2sel = s.sel;   imm = s.imm;       rd_en = s.rd_en; rd = s.rd;
        out_ready = s.ordy; wb_we = s.we; wb_rd = s.wrd; wb_data = s.wd; flush = s.fl;
        #1;
        chk("busy_vec", busy_vec, busy_bits());
        chk("out_valid", out_valid, m_valid);
        rs2_reg   = s.rs2_en && (s.sel == 2'd0 || s.sel == 2'd3);
        exp_ready = !s.fl && !blocked(s, s.rs1_en, s.rs1) && !blocked(s, rs2_reg, s.rs2) &&
                    !blocked(s, s.rd_en, s.rd) && (!m_valid || s.ordy);
        chk("iss_ready", iss_ready, exp_ready);
        acc = s.v && exp_ready;
        if (acc) begin
            e.rs1 = s.rs1_en ? src(s, s.rs1) : 64'd0;
            if (s.sel == 2'd1)      e.rs2 = s.imm;
            else if (s.sel == 2'd2) e.rs2 = 64'd0;
            else                    e.rs2 = s.rs2_en ? src(s, s.rs2) : 64'd0;
            e.rd = s.rd_en ? s.rd : 5'd0;
            exp_q.push_back(e);
        end
        if (s.we && s.wrd != 0) m_regs[s.wrd] = s.wd;
        if (s.fl) begin
            for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
        end else begin
            if (s.we) m_busy[s.wrd] = 1'b0;
            if (acc && s.rd_en && s.rd != 0) m_busy[s.rd] = 1'b1;
        end
        if (s.fl)        m_valid = 1'b0;
        else if (acc)    m_valid = 1'b1;
        else if (s.ordy) m_valid = 1'b0;
    endtask

    task automatic do_reset(input logic with_wb);
        @(posedge clk);
        #2;
        iss_valid = 1'b0; flush = 1'b0;
        wb_we = with_wb; wb_rd = 5'd6; wb_data = {$urandom, $urandom};
        rst_ni = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_busy", busy_vec, 32'd0);
        chk("rst_out_rs1", out_rs1, 64'd0);
        chk("rst_out_rs2", out_rs2, 64'd0);
        chk("rst_out_rd", out_rd, 5'd0);
        for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
        m_valid = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #2;
        rst_ni = 1'b1;
        wb_we  = 1'b0;
    endtask

    // Monitor: an output transfers when valid meets ready at the coming edge; a flush drops it.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_ni && out_valid && (flush || out_ready)) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_output: got rs1=%h rs2=%h rd=%0d expected none",
                             out_rs1, out_rs2, out_rd);
                end else begin
                    e = exp_q.pop_front();
                    if (!flush) begin
                        chk("out_rs1_d", out_rs1, e.rs1);
                        chk("out_rs2_d", out_rs2, e.rs2);
                        chk("out_rd", out_rd, {59'd0, e.rd});
                    end
                end
            end
        end
    end

    initial begin
        stim_t s;
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = 64'd0;
            m_busy[i] = 1'b0;
        end
        repeat (2) @(posedge clk);
        do_reset(1'b0);

        for (int i = 1; i < 32; i++) begin
            s = idle(); s.we = 1'b1; s.wrd = 5'(i); s.wd = {$urandom, $urandom}; step(s);
        end

        // Register read plus immediate
        s = idle(); s.we = 1; s.wrd = 5; s.wd = 64'h1234; step(s);
        s = idle(); s.v = 1; s.rs1_en = 1; s.rs1 = 5; s.sel = 1; s.imm = 64'h10; step(s);
        // RAW stall released by a same-cycle write-back with bypass
        s = idle(); s.v = 1; s.rd_en = 1; s.rd = 7; step(s);
        s = idle(); s.v = 1; s.rs1_en = 1; s.rs1 = 7; step(s);
        s.we = 1; s.wrd = 7; s.wd = 64'hAA; step(s);
        // x0 source and destination
        s = idle(); s.v = 1; s.rs1_en = 1; s.rs1 = 0; s.rd_en = 1; s.rd = 0; step(s);
        s = idle(); s.we = 1; s.wrd = 0; s.wd = 64'hFF; step(s);
        s = idle(); s.v = 1; s.rs1_en = 1; s.rs1 = 0; s.rs2_en = 1; s.rs2 = 0; step(s);
        // Back-pressure then simultaneous drain and accept
        s = idle(); s.v = 1; s.rs1_en = 1; s.rs1 = 5; s.rs2_en = 1; s.rs2 = 7; s.ordy = 0; step(s);
        s.rs1 = 9; step(s); step(s); step(s);
        s.ordy = 1; step(s);
        // WAW stall, then set-wins on the same index
        s = idle(); s.v = 1; s.rd_en = 1; s.rd = 3; step(s);
        step(s); step(s);
        s.we = 1; s.wrd = 3; s.wd = 64'h3333; step(s);
        s = idle(); s.we = 1; s.wrd = 3; s.wd = 64'h3334; step(s);
        // Flush clears busy bits and the output register but keeps the array
        s = idle(); s.v = 1; s.rd_en = 1; s.rd = 4; step(s);
        s.rd = 9; step(s);
        s = idle(); s.fl = 1; s.ordy = 0; step(s);
        s = idle(); s.v = 1; s.rs1_en = 1; s.rs1 = 4; step(s);
        s = idle(); step(s);

        for (int n = 0; n < 3000; n++) begin
            if (n == 1500) do_reset(1'b1);
            s.v      = ($urandom_range(0, 3) != 0);
            s.rs1_en = ($urandom_range(0, 3) != 0);
            s.rs1    = 5'($urandom_range(0, 7));
            s.rs2_en = ($urandom_range(0, 3) != 0);
            s.rs2    = 5'($urandom_range(0, 7));
            s.sel    = 2'($urandom_range(0, 3));
            s.imm    = {$urandom, $urandom};
            s.rd_en  = ($urandom_range(0, 3) != 0);
            s.rd     = 5'($urandom_range(0, 7));
            s.we     = ($urandom_range(0, 2) == 0);
            s.wrd    = ($urandom_range(0, 3) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
            s.wd     = {$urandom, $urandom};
            s.fl     = ($urandom_range(0, 39) == 0);
            s.ordy   = s.fl ? 1'b0 : ($urandom_range(0, 3) != 0);
            step(s);
        end

        s = idle();
        step(s); step(s); step(s);
        chk("drain_queue", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
